pr_stage_skid: RTL and testbench

- Parametrised pipeline-stage register with a valid/ready handshake, an optional skid entry, a synchronous flush, and saturating stall/drop counters.
- It is the next generation of the fixed D→E stage register, generalised to any payload width.
- One instance sits between each pair of pipeline stages.
- The D→E payload is carried as a packed struct instead of individual ports.

---
 rtl/pr_pkg.sv | 31 +++
 rtl/pr_sat_counter.sv | 38 +++
 rtl/pr_stage_skid.sv | 156 +++++++++++++++
 tb/tb_pr_stage_skid.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pr_pkg.sv
`default_nettype none
// ============================================================================
// pr_pkg : shared types for the pipeline-stage registers (Rev 1.0)
// ============================================================================
package pr_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_st_t;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic [2:0]  alucontrol;
    logic        alusrc;
    logic        regdst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] signimm;
  } de_payload_t;

  localparam int DE_W = $bits(de_payload_t);

endpackage
`default_nettype wire

// File: rtl/pr_sat_counter.sv
`default_nettype none
// ============================================================================
// pr_sat_counter : saturating up-counter with a multi-bit increment (Rev 1.0)
// ============================================================================
module pr_sat_counter
  import pr_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] count
);

  localparam int SUM_W = CNT_W + INC_W;

  logic [CNT_W-1:0] r_count;
  logic [SUM_W-1:0] w_sum;

  // Sum is widened so any carry out of CNT_W bits signals saturation.
  assign w_sum = {{INC_W{1'b0}}, r_count} + {{CNT_W{1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (|w_sum[SUM_W-1:CNT_W]) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[CNT_W-1:0];
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pr_stage_skid.sv
`default_nettype none
// ============================================================================
// pr_stage_skid : valid/ready pipeline stage with optional skid entry, flush
//                 and saturating stall/drop counters (Rev 1.0)
// ============================================================================
module pr_stage_skid
  import pr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic       w_acc;
  logic       w_pop;
  logic       w_skid_valid;
  logic       w_stall_inc;
  logic [1:0] w_drop_inc;

  assign w_acc = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      skid_st_t          r_state;
      skid_st_t          w_next;
      logic [DATA_W-1:0] r_main;
      logic [DATA_W-1:0] r_skid;
      logic              r_in_ready;
      logic              w_ld_main_in;
      logic              w_ld_main_skid;
      logic              w_ld_skid;

      always_comb begin
        w_next         = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
          EMPTY: begin
            if (w_acc) begin
              w_next       = BUSY;
              w_ld_main_in = 1'b1;
            end
          end
          BUSY: begin
            if (w_acc && w_pop) begin
              w_ld_main_in = 1'b1;
            end else if (w_acc) begin
              w_next    = FULL;
              w_ld_skid = 1'b1;
            end else if (w_pop) begin
              w_next = EMPTY;
            end
          end
          FULL: begin
            if (w_pop) begin
              w_next         = BUSY;
              w_ld_main_skid = 1'b1;
            end
          end
          default: w_next = EMPTY;
        endcase
      end

      // in_ready is registered from the next state, so out_ready never
      // reaches it combinationally.
      always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
          r_state    <= EMPTY;
          r_main     <= '0;
          r_skid     <= '0;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_next;
          r_in_ready <= (w_next != FULL);
          if (w_ld_main_in) begin
            r_main <= in_data;
          end else if (w_ld_main_skid) begin
            r_main <= r_skid;
          end
          if (w_ld_skid) begin
            r_skid <= in_data;
          end
        end
      end

      assign in_ready     = r_in_ready;
      assign out_valid    = (r_state != EMPTY);
      assign out_data     = r_main;
      assign w_skid_valid = (r_state == FULL);
    end else begin : g_noskid
      logic              r_valid;
      logic [DATA_W-1:0] r_main;

      always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
          r_valid <= 1'b0;
          r_main  <= '0;
        end else if (w_acc) begin
          r_valid <= 1'b1;
          r_main  <= in_data;
        end else if (w_pop) begin
          r_valid <= 1'b0;
        end
      end

      assign in_ready     = !r_valid || out_ready;
      assign out_valid    = r_valid;
      assign out_data     = r_main;
      assign w_skid_valid = 1'b0;
    end
  endgenerate

  assign w_stall_inc = out_valid && !out_ready;

  // A beat popped in the flush cycle still leaves, so only an unpopped main counts.
  assign w_drop_inc = flush ? ({1'b0, (out_valid && !out_ready)} +
                               {1'b0, w_skid_valid} +
                               {1'b0, w_acc})
                            : 2'd0;

  pr_sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (1)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_stall_inc),
    .count   (stall_cnt)
  );

  pr_sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (2)
  ) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_drop_inc),
    .count   (drop_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pr_stage_skid.sv
`default_nettype none
// ============================================================================
// tb_pr_stage_skid : randomized/directed bench for pr_stage_skid against a
//                    queue-style reference model (Rev 1.0)
// ============================================================================
module tb_pr_stage_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        flush;
  logic        out_ready;
  logic        in_valid;
  logic [31:0] in_data   [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [31:0] out_data  [3];
  logic [15:0] stall0, drop0, stall2, drop2;
  logic [3:0]  stall1, drop1;

  // Instance 0: SKID=1 / 16-bit counters, 1: SKID=1 / 4-bit counters, 2: SKID=0.
  pr_stage_skid #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .stall_cnt(stall0), .drop_cnt(drop0));

  pr_stage_skid #(.DATA_W(32), .SKID(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .stall_cnt(stall1), .drop_cnt(drop1));

  pr_stage_skid #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
    .stall_cnt(stall2), .drop_cnt(drop2));

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  int          m_cnt   [3];
  logic [31:0] m_dat   [3][2];
  logic [31:0] m_last  [3];
  int          m_stall [3];
  int          m_drop  [3];
  logic [31:0] src     [3];
  int          c_max   [3] = '{65535, 15, 65535};
  bit          m_skid  [3] = '{1'b1, 1'b1, 1'b0};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_stall(input int k);
    if (k == 0) return {16'd0, stall0};
    if (k == 1) return {28'd0, stall1};
    return {16'd0, stall2};
  endfunction

  function automatic logic [31:0] get_drop(input int k);
    if (k == 0) return {16'd0, drop0};
    if (k == 1) return {28'd0, drop1};
    return {16'd0, drop2};
  endfunction

  task automatic cycle(input logic v, input logic r, input logic f, input logic rn, input bit chk);
    @(negedge clk);
    reset_n   = rn;
    flush     = f;
    out_ready = r;
    in_valid  = v;
    for (int k = 0; k < 3; k++) in_data[k] = src[k];
    #1;
    for (int k = 0; k < 3; k++) begin
      bit ev, eir, acc, pop;
      int d;
      ev  = (m_cnt[k] > 0);
      eir = m_skid[k] ? (m_cnt[k] < 2) : (!ev || r);
      if (chk) begin
        check($sformatf("u%0d.out_valid", k), {31'd0, out_valid[k]}, {31'd0, ev});
        check($sformatf("u%0d.in_ready", k), {31'd0, in_ready[k]}, {31'd0, eir});
        check($sformatf("u%0d.out_data", k), out_data[k], m_last[k]);
        check($sformatf("u%0d.stall_cnt", k), get_stall(k), 32'(m_stall[k]));
        check($sformatf("u%0d.drop_cnt", k), get_drop(k), 32'(m_drop[k]));
      end
      acc = v && eir;
      pop = ev && r;
      if (!rn) begin
        m_cnt[k]   = 0;
        m_last[k]  = '0;
        m_stall[k] = 0;
        m_drop[k]  = 0;
      end else begin
        if (ev && !r && m_stall[k] < c_max[k]) m_stall[k]++;
        if (f) begin
          d = m_cnt[k] - (pop ? 1 : 0) + (acc ? 1 : 0);
          m_drop[k] = (m_drop[k] + d > c_max[k]) ? c_max[k] : m_drop[k] + d;
          m_cnt[k]  = 0;
          m_last[k] = '0;
        end else begin
          if (pop) begin
            m_dat[k][0] = m_dat[k][1];
            m_cnt[k]--;
          end
          if (acc) begin
            m_dat[k][m_cnt[k]] = src[k];
            m_cnt[k]++;
          end
          if (m_cnt[k] > 0) m_last[k] = m_dat[k][0];
        end
        if (acc) src[k]++;
      end
    end
    @(posedge clk);
  endtask

  task automatic set_src(input logic [31:0] val);
    for (int k = 0; k < 3; k++) src[k] = val;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data[k] = '0;
      m_cnt[k] = 0; m_last[k] = '0; m_stall[k] = 0; m_drop[k] = 0;
      m_dat[k][0] = '0; m_dat[k][1] = '0;
    end

    // Reset with a beat offered: it must be ignored.
    set_src(32'hDEAD);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);

    // Streaming 0x1..0x8 with downstream always ready.
    set_src(32'h1);
    for (int i = 0; i < 10; i++) cycle(i < 8, 1, 0, 1, 1);

    // Backpressure fill with 0xA, 0xB, 0xC, then release.
    set_src(32'hA);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cycle(src[0] <= 32'hC, 1, 0, 1, 1);

    // Flush while FULL with a beat offered, then while BUSY with an acc.
    set_src(32'hA);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 1, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 1, 1, 1);
    cycle(0, 0, 0, 1, 1);

    // Saturate stall_cnt on the 4-bit instance.
    cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 1);

    // Repeated two-beat flushes drive the 4-bit drop_cnt through 14 to 15.
    for (int j = 0; j < 6; j++) begin
      cycle(1, 0, 0, 1, 1);
      cycle(1, 0, 0, 1, 1);
      cycle(1, 0, 1, 1, 1);
    end
    cycle(0, 1, 0, 1, 1);

    // Toggling out_ready while streaming 0x10..0x13.
    set_src(32'h10);
    for (int i = 0; i < 12; i++) cycle(src[2] <= 32'h13, (i % 2) == 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 1);

    // Randomized traffic including occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0,
            ($urandom % 60) != 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
